fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core, sitting directly upstream of the next-PC and operand selection muxes and the decode stage. It holds the program counter and issues one instruction-memory read at a time. It delivers each fetched instruction with its PC to decode over a valid/ready handshake, and applies branch/jump redirects from execute, including discarding any in-flight fetch.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_pc_reg.sv | 21 ++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: FSM encodings, instruction width, NOP word and PC step.
// Also holds the 2:1 select used for next-PC choice.
package fetch_unit_pkg;

  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_HOLD = 2'd2;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned XLEN_MAX = 64;
  localparam int unsigned PC_STEP  = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Operands are carried at the widest supported XLEN; callers narrow the result.
  function automatic logic [XLEN_MAX-1:0] mux2(input logic                sel,
                                               input logic [XLEN_MAX-1:0] a0,
                                               input logic [XLEN_MAX-1:0] a1);
    return sel ? a1 : a0;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, load on enable.
module pc_reg #(
  parameter int unsigned N        = 64,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, registered valid/ready
// delivery to decode, and redirect handling that drops an in-flight response.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic               imem_req_valid,
  output logic [N-1:0]       imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               out_valid,
  output logic [N-1:0]       out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  logic [1:0]         state;
  logic [1:0]         state_d;
  logic               drop;
  logic               drop_d;
  logic               out_valid_d;
  logic [N-1:0]       out_pc_d;
  logic [INSTR_W-1:0] out_instr_d;

  logic               pc_en;
  logic [N-1:0]       pc;
  logic [N-1:0]       pc_next;
  logic [N-1:0]       pc_inc;
  logic [N-1:0]       redirect_tgt;

  // Low two bits of the target are forced to zero; PC increment wraps modulo 2^N.
  assign redirect_tgt = redirect_pc & ~N'(3);
  assign pc_inc       = pc + N'(PC_STEP);
  assign pc_next      = N'(mux2(redirect_valid, XLEN_MAX'(pc_inc), XLEN_MAX'(redirect_tgt)));

  pc_reg #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_next),
    .q   (pc)
  );

  // Request outputs decode only registered state.
  assign imem_req_valid = (state == FETCH_REQ);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_REQ;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= {N{1'b0}};
      out_instr <= NOP_INSTR;
    end else begin
      state     <= state_d;
      drop      <= drop_d;
      out_valid <= out_valid_d;
      out_pc    <= out_pc_d;
      out_instr <= out_instr_d;
    end
  end

  always_comb begin
    state_d     = state;
    drop_d      = drop;
    out_valid_d = out_valid;
    out_pc_d    = out_pc;
    out_instr_d = out_instr;
    pc_en       = 1'b0;

    case (state)
      FETCH_REQ: begin
        pc_en = redirect_valid;
        if (imem_req_ready) begin
          state_d = FETCH_WAIT;
          if (redirect_valid) begin
            drop_d = 1'b1;
          end
        end
      end

      FETCH_WAIT: begin
        pc_en = redirect_valid;
        if (imem_resp_valid) begin
          if (drop || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = FETCH_REQ;
          end else begin
            out_instr_d = imem_resp_data;
            out_pc_d    = pc;
            out_valid_d = 1'b1;
            state_d     = FETCH_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end

      FETCH_HOLD: begin
        // A redirect without a handshake discards the held instruction.
        if (out_ready || redirect_valid) begin
          out_valid_d = 1'b0;
          pc_en       = 1'b1;
          state_d     = FETCH_REQ;
        end
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, backpressure,
// redirects in WAIT/HOLD/REQ, reset during WAIT and PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  logic        rst1;
  logic        redirect_valid1;
  logic [63:0] redirect_pc1;
  logic        imem_req_valid1;
  logic [63:0] imem_req_addr1;
  logic        imem_req_ready1;
  logic        imem_resp_valid1;
  logic [31:0] imem_resp_data1;
  logic        out_valid1;
  logic [63:0] out_pc1;
  logic [31:0] out_instr1;
  logic        out_ready1;

  int total;
  int bad;

  fetch_unit #(.N(64), .RESET_PC(64'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_ready       (out_ready)
  );

  fetch_unit #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk             (clk),
    .rst             (rst1),
    .redirect_valid  (redirect_valid1),
    .redirect_pc     (redirect_pc1),
    .imem_req_valid  (imem_req_valid1),
    .imem_req_addr   (imem_req_addr1),
    .imem_req_ready  (imem_req_ready1),
    .imem_resp_valid (imem_resp_valid1),
    .imem_resp_data  (imem_resp_data1),
    .out_valid       (out_valid1),
    .out_pc          (out_pc1),
    .out_instr       (out_instr1),
    .out_ready       (out_ready1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst              = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = 64'h0;
    imem_req_ready   = 1'b0;
    imem_resp_valid  = 1'b0;
    imem_resp_data   = 32'h0;
    out_ready        = 1'b0;
    rst1             = 1'b1;
    redirect_valid1  = 1'b0;
    redirect_pc1     = 64'h0;
    imem_req_ready1  = 1'b0;
    imem_resp_valid1 = 1'b0;
    imem_resp_data1  = 32'h0;
    out_ready1       = 1'b0;

    // Reset held for two cycles
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_instr", 64'(out_instr), 64'h13);
    check("rst_out_pc", out_pc, 64'h0);

    // First cycle with rst low: request to RESET_PC
    rst = 1'b0;
    check("first_req_valid", 64'(imem_req_valid), 64'h1);
    check("first_req_addr", imem_req_addr, 64'h0);

    // Sequential fetch #1 at PC 0
    imem_req_ready = 1'b1;
    step();
    check("wait_req_valid", 64'(imem_req_valid), 64'h0);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00A0_0093;
    out_ready       = 1'b1;
    step();
    imem_resp_valid = 1'b0;
    check("f1_out_valid", 64'(out_valid), 64'h1);
    check("f1_out_pc", out_pc, 64'h0);
    check("f1_out_instr", 64'(out_instr), 64'h00A0_0093);
    step();
    check("f2_req_valid", 64'(imem_req_valid), 64'h1);
    check("f2_req_addr", imem_req_addr, 64'h4);
    check("f1_consumed", 64'(out_valid), 64'h0);

    // Sequential fetch #2 at PC 4
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0010_0113;
    step();
    imem_resp_valid = 1'b0;
    check("f2_out_pc", out_pc, 64'h4);
    check("f2_out_instr", 64'(out_instr), 64'h0010_0113);
    step();
    check("f3_req_addr", imem_req_addr, 64'h8);

    // Fetch #3 at PC 8 held under decode backpressure
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0513;
    out_ready       = 1'b0;
    step();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'h1);
      check("bp_out_pc", out_pc, 64'h8);
      check("bp_out_instr", 64'(out_instr), 64'h0000_0513);
      check("bp_no_req", 64'(imem_req_valid), 64'h0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(out_valid), 64'h0);
    check("bp_release_addr", imem_req_addr, 64'hC);

    // Redirect to 0x100 while waiting: the pending response is dropped
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    step();
    redirect_valid = 1'b0;
    check("rw_still_wait", 64'(imem_req_valid), 64'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    check("rw_dropped_valid", 64'(out_valid), 64'h0);
    check("rw_req_valid", 64'(imem_req_valid), 64'h1);
    check("rw_req_addr", imem_req_addr, 64'h100);

    // Fetch at 0x100, then handshake plus redirect to 0x203 (low bits ignored)
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    out_ready       = 1'b0;
    step();
    imem_resp_valid = 1'b0;
    check("rh_out_pc", out_pc, 64'h100);
    check("rh_out_instr", 64'(out_instr), 64'h1234_5678);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h203;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("rh_consumed", 64'(out_valid), 64'h0);
    check("rh_req_addr", imem_req_addr, 64'h200);
    step();
    check("rh_once_valid", 64'(out_valid), 64'h0);
    check("rh_hold_req", 64'(imem_req_valid), 64'h1);

    // Redirect in REQ without ready: retarget and keep requesting
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    step();
    redirect_valid = 1'b0;
    check("rr_req_valid", 64'(imem_req_valid), 64'h1);
    check("rr_req_addr", imem_req_addr, 64'h300);

    // Reset asserted in WAIT; the late response must be ignored
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("rstw_in_wait", 64'(imem_req_valid), 64'h0);
    rst = 1'b1;
    step();
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_F00D;
    step();
    imem_resp_valid = 1'b0;
    check("rstw_out_valid", 64'(out_valid), 64'h0);
    check("rstw_out_instr", 64'(out_instr), 64'h13);
    check("rstw_req_valid", 64'(imem_req_valid), 64'h1);
    check("rstw_req_addr", imem_req_addr, 64'h0);

    // PC wrap-around from all-ones-minus-3
    rst1 = 1'b0;
    check("wrap_first_addr", imem_req_addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready1 = 1'b1;
    step();
    imem_req_ready1  = 1'b0;
    imem_resp_valid1 = 1'b1;
    imem_resp_data1  = 32'h0000_0073;
    out_ready1       = 1'b1;
    step();
    imem_resp_valid1 = 1'b0;
    check("wrap_out_pc", out_pc1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wrap_req_valid", 64'(imem_req_valid1), 64'h1);
    check("wrap_req_addr", imem_req_addr1, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
